uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver, 8N1, LSB first, idle-high line. Counterpart of the team's uart_tx.
- Sits between the FPGA RX pin and the command/data parser.
- Synchronises the asynchronous rx line, validates the start bit at mid-bit, and samples each data bit at its centre.
- Presents each byte with a one-cycle valid strobe, or flags a framing error.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (localparam), clocks per bit, 5208 at defaults. Legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2 (localparam, integer divide), start-bit validation delay.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on clk rising edge; 0 = reset.
- rx  input  1  asynchronous UART receive line, idle high.
- rx_data  output  8  last correctly framed byte; holds until the next good byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
- frame_err  output  1  one-cycle pulse: stop bit sampled low; byte discarded.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset==0 at edge): state=IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, busy=0, clk_count=0, bit_index=0, shift=0. Both synchroniser flops are set to 1. Reset wins over every other event, including mid-frame; no partial byte is ever output.
- Synchroniser: two flops, rx -> s1 -> rx_sync. All decisions use rx_sync only.
- clk_count is 16 bits and bit_index is 3 bits. clk_count clears on every state transition and on every bit sample.
- IDLE: if rx_sync==0, go to START with clk_count=0.
- START: increment clk_count. When clk_count==HALF_BIT-1:
  - rx_sync==0: go to DATA, clk_count=0, bit_index=0.
  - rx_sync==1: glitch; return to IDLE. No output pulse.
- DATA: increment clk_count. When clk_count==CLKS_PER_BIT-1:
  - Sample rx_sync into shift[bit_index] (LSB first) and clear clk_count.
  - If bit_index==7, go to STOP; otherwise bit_index+1.
- STOP: increment clk_count. When clk_count==CLKS_PER_BIT-1, sample rx_sync:
  - 1: rx_data<=shift, rx_valid=1 for exactly one cycle, go to IDLE.
  - 0: frame_err=1 for exactly one cycle, rx_data unchanged, go to BREAK.
- BREAK: wait until rx_sync==1, then go to IDLE. A held-low line (break) must not be decoded as repeated 0x00 bytes.
- Timing: edge 0 is the first clk edge at which s1 captures rx==0. rx_valid (or frame_err) is high during the cycle after edge 2+HALF_BIT+9*CLKS_PER_BIT.
- Back-to-back frames: the return to IDLE occurs mid stop bit. The next start edge, arriving at least HALF_BIT cycles later, is accepted with no lost byte.
- No consumer handshake. The consumer must take rx_data on the rx_valid cycle. rx_data is stable until the next rx_valid.
- rx_valid and frame_err are never high in the same cycle.

Test Plan:
Bench parameters: CLK_FREQ=1000000, BAUD_RATE=100000, so CLKS_PER_BIT=10 and HALF_BIT=5.
- Single byte: drive 0xA5 framed 8N1 at 10 clk/bit -> rx_valid pulses once, 1 cycle wide, exactly 97 edges after edge 0; rx_data==8'hA5; frame_err stays 0.
- Back-to-back: 0x00, 0xFF, 0x3C with no idle gap -> three rx_valid pulses with data 00, FF, 3C in order; busy drops between frames.
- Glitch: rx low for 3 clocks, then high -> state returns to IDLE; no rx_valid or frame_err; the next valid byte 0x5A is received correctly.
- Framing error / break: frame 0x81 with stop bit 0, then rx held low for 50 bit times -> one frame_err pulse; no rx_valid; rx_data keeps its previous value; after rx returns high, byte 0x42 is received correctly.
- Reset mid-frame: assert reset low for 1 cycle during data bit 4 -> all outputs reset; no pulse for the aborted frame; the following 0x99 is received correctly.
- Loopback: uart_tx (same parameters) drives rx with 256 random bytes -> all 256 received in order; zero frame_err.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle between the UART receiver and its consumer.
// The master side is the receiver; the slave side drives the line and takes bytes.
`timescale 1ns / 1ps
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, centre sampling,
// one-cycle valid / framing-error strobes and break handling.
`timescale 1ns / 1ps
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input logic      clk,
    input logic      reset,
    uart_rx_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [15:0] BitLast      = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast     = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e      state_q, state_d;
    logic        s1_q, s1_d;
    logic        rx_sync_q, rx_sync_d;
    logic [15:0] clk_count_q, clk_count_d;
    logic [2:0]  bit_index_q, bit_index_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        frame_err_q, frame_err_d;

    always_comb begin
        s1_d        = bus.rx;
        rx_sync_d   = s1_q;
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_index_d = bit_index_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            StIdle: begin
                clk_count_d = '0;
                bit_index_d = '0;
                if (!rx_sync_q) state_d = StStart;
            end
            StStart: begin
                if (clk_count_q == HalfLast) begin
                    clk_count_d = '0;
                    bit_index_d = '0;
                    // A line that is high again at mid start bit was only a glitch
                    state_d     = rx_sync_q ? StIdle : StData;
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            StData: begin
                if (clk_count_q == BitLast) begin
                    clk_count_d          = '0;
                    shift_d[bit_index_q] = rx_sync_q;
                    if (bit_index_q == 3'd7) state_d = StStop;
                    else                     bit_index_d = bit_index_q + 3'd1;
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            StStop: begin
                if (clk_count_q == BitLast) begin
                    clk_count_d = '0;
                    if (rx_sync_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    clk_count_d = clk_count_q + 16'd1;
                end
            end
            StBreak: begin
                // Hold off until the line is released so a break is not read as 0x00 bytes
                clk_count_d = '0;
                if (rx_sync_q) state_d = StIdle;
            end
            default: begin
                state_d     = StIdle;
                clk_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            s1_q        <= 1'b1;
            rx_sync_q   <= 1'b1;
            clk_count_q <= '0;
            bit_index_q <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            rx_sync_q   <= rx_sync_d;
            clk_count_q <= clk_count_d;
            bit_index_q <= bit_index_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serialised frames push expected bytes/errors with their
// due cycle; an independent monitor pops and compares on every output strobe.
`timescale 1ns / 1ps
module tb_uart_rx;
    localparam int unsigned ClkFreq  = 1000000;
    localparam int unsigned BaudRate = 100000;
    localparam int Cpb  = ClkFreq / BaudRate;
    localparam int Half = Cpb / 2;
    // Edges from the synchroniser's first capture of the start bit to the strobe edge
    localparam int Lat  = 2 + Half + 9 * Cpb;

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk;
    logic reset;
    uart_rx_if bus_if ();

    uart_rx #(
        .CLK_FREQ (ClkFreq),
        .BAUD_RATE(BaudRate)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] model_last = 8'h00;
    bit         prev_valid = 1'b0;
    bit         prev_any   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compares every strobe against the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (bus_if.rx_valid || bus_if.frame_err) begin
            check("valid_and_ferr_exclusive", int'(bus_if.rx_valid && bus_if.frame_err), 0);
            check("pulse_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pulse_kind_ferr", int'(bus_if.frame_err), int'(e.ferr));
                check("rx_data", int'(bus_if.rx_data), int'(e.data));
                check("pulse_cycle", cyc, e.due);
            end
        end
        if (bus_if.rx_valid && prev_valid) check("rx_valid_width", 2, 1);
        if (prev_valid) check("busy_low_after_byte", int'(bus_if.busy), 0);
        prev_valid = bus_if.rx_valid;
        prev_any   = bus_if.rx_valid || bus_if.frame_err;
    end

    task automatic drive_bits(input logic b, input int n);
        bus_if.rx = b;
        repeat (n) @(negedge clk);
    endtask

    // Reference transmitter: start, 8 data bits LSB first, chosen stop bit
    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.due = cyc + 1 + Lat;
        if (stop) begin
            e.ferr     = 1'b0;
            e.data     = d;
            model_last = d;
        end else begin
            e.ferr = 1'b1;
            e.data = model_last;
        end
        exp_q.push_back(e);
        drive_bits(1'b0, Cpb);
        for (int i = 0; i < 8; i++) drive_bits(d[i], Cpb);
        drive_bits(stop, Cpb);
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog_timeout actual=%0d cycles expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] partial;
        reset     = 1'b0;
        bus_if.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_rx_data", int'(bus_if.rx_data), 0);
        check("reset_rx_valid", int'(bus_if.rx_valid), 0);
        check("reset_frame_err", int'(bus_if.frame_err), 0);
        check("reset_busy", int'(bus_if.busy), 0);
        reset = 1'b1;
        drive_bits(1'b1, 20);

        send_frame(8'hA5, 1'b1);
        drive_bits(1'b1, 20);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        drive_bits(1'b1, 20);

        drive_bits(1'b0, 3);
        drive_bits(1'b1, 12);
        check("glitch_returns_idle", int'(bus_if.busy), 0);
        send_frame(8'h5A, 1'b1);
        drive_bits(1'b1, 20);

        send_frame(8'h81, 1'b0);
        drive_bits(1'b0, 50 * Cpb);
        check("break_holds_rx_data", int'(bus_if.rx_data), 8'h5A);
        drive_bits(1'b1, 20);
        send_frame(8'h42, 1'b1);
        drive_bits(1'b1, 20);

        // Abort a frame with reset during data bit 4
        partial = 8'h99;
        drive_bits(1'b0, Cpb);
        for (int i = 0; i < 4; i++) drive_bits(partial[i], Cpb);
        drive_bits(partial[4], Half);
        reset = 1'b0;
        @(negedge clk);
        reset      = 1'b1;
        bus_if.rx  = 1'b1;
        model_last = 8'h00;
        check("midframe_reset_rx_data", int'(bus_if.rx_data), 0);
        check("midframe_reset_busy", int'(bus_if.busy), 0);
        drive_bits(1'b1, 30);
        send_frame(8'h99, 1'b1);
        drive_bits(1'b1, 20);

        for (int i = 0; i < 256; i++) begin
            send_frame(8'($urandom), 1'b1);
            drive_bits(1'b1, int'($urandom_range(0, 15)));
        end

        drive_bits(1'b1, 200);
        check("all_frames_seen", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
